tx_response_parser: RTL
=======================

TX_RESPONSE_PARSER -- requirements
Module: tx_response_parser

Interface
REQ-001 SHALL have parameter BASE, default 0, settings-bus base address of this block's registers.
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clear  input  1  synchronous clear; same effect as reset except settings registers.
REQ-005 SHALL have ports set_stb/set_addr/set_data  input  1/8/32  settings bus.
REQ-006 SHALL have ports i_tdata/i_tlast/i_tvalid/i_tready  in/in/in/out  64/1/1/1  inbound context-packet stream.
REQ-007 SHALL have ports evt_sid/evt_seqnum/evt_time/evt_code  output  32/12/64/64  decoded event fields.
REQ-008 SHALL have ports evt_is_error/evt_valid/evt_ready  out/out/in  1/1/1  event handshake.
REQ-009 SHALL have ports bad_pkt_cnt/seq_gap_cnt  output  16/16  saturating diagnostic counters.

Function
REQ-010 SHALL accept packets of exactly 3 beats: beat0 {hdr[31:0], sid[31:0]}, beat1 vita_time[63:0], beat2 body[63:0] with i_tlast.
REQ-011 SHALL treat hdr[31:28]==4'h4 as context type, hdr[27:16] as reply seqnum, hdr[15:0]==16'd6 as required length.
REQ-012 SHALL use states HDR -> TIME -> BODY -> EMIT -> HDR; DRAIN for malformed packets.
REQ-013 SHALL transfer a beat only when i_tvalid & i_tready; i_tready=1 in HDR/TIME/BODY/DRAIN, 0 in EMIT.
REQ-014 SHALL go HDR->DRAIN if type/length mismatch, or SID filter enabled and sid != filter SID; if that beat has i_tlast, return to HDR instead.
REQ-015 SHALL go to HDR (not EMIT) and count bad packet if i_tlast arrives on beat0/beat1; SHALL go to DRAIN and count if beat2 lacks i_tlast.
REQ-016 SHALL stay in DRAIN consuming beats until a beat with i_tlast, then HDR; one bad_pkt_cnt increment per malformed packet.
REQ-017 SHALL classify body[63:12]==0 as ack (evt_is_error=0, evt_code=body); else error (evt_is_error=1, evt_code=body).
REQ-018 SHALL assert evt_valid the cycle after the beat2 transfer, holding all evt_* stable until evt_valid & evt_ready.
REQ-019 SHALL return to HDR on the evt handshake cycle and may accept the next beat0 the following cycle (min 4 cycles/packet).
REQ-020 SHALL saturate counters at 16'hFFFF, never wrapping.
REQ-021 SHALL decode set_addr==BASE as filter SID [31:0], BASE+1 bit0 as filter enable; both reset to 0.
REQ-022 SHALL on clear abort any packet: state HDR, evt_valid=0, counters 0, expected seqnum unset; partial packet then arriving is parsed as new beat0.

Reset
REQ-023 SHALL on reset_n low asynchronously set state HDR, evt_valid=0, i_tready=0, all evt_* fields 0, both counters 0, settings 0.
REQ-024 SHALL hold i_tready=0 only while reset_n low; first cycle after release i_tready=1.
REQ-025 SHALL, on reset mid-packet, treat the next transferred beat as beat0.

Configuration
REQ-026 SHALL compile reply-seqnum continuity checking only when TX_RESP_PARSER_SEQ_CHECK_EN is defined.
REQ-027 SHALL with the macro: after first good packet, expect seqnum+1 mod 4096; on mismatch increment seq_gap_cnt once, resync expected to received+1, still emit event.
REQ-028 SHALL without the macro: seq_gap_cnt tied to 0, no seqnum state registers.

Structure
REQ-029 SHALL place type nibble 4'h4, length 16'd6, register offsets and state enum in package tx_resp_pkg.
REQ-030 SHALL isolate beat0 header/SID validation in sub-module tx_resp_hdr_check (combinational plus filter registers).

Verification
REQ-031 SHALL test ack: hdr 32'h4001_0006, sid 32'h0000_0010, time 64'h100, body 64'h0000_0000_0000_0ABC -> one event, is_error=0, seqnum 1, code 12'hABC.
REQ-032 SHALL test error: body 64'h0000_0008_0000_0000 -> evt_is_error=1, code identical.
REQ-033 SHALL test backpressure: evt_ready low 10 cycles -> i_tready low 10 cycles, evt fields stable, no beat lost.
REQ-034 SHALL test malformed: length 16'd8, 5-beat packet -> no event, bad_pkt_cnt=1, next good packet decoded.
REQ-035 SHALL test wrap (macro on): seqnums 4095,0,2 -> seq_gap_cnt=1, three events.
REQ-036 SHALL test reset_n asserted mid-beat1 -> outputs zero immediately; a fresh packet after release decodes correctly.

Source files
------------

// File: rtl/tx_resp_pkg.sv
// Shared constants, header layout and FSM encoding for the TX response parser.
package tx_resp_pkg;

   localparam int unsigned DATA_W     = 64;
   localparam int unsigned SID_W      = 32;
   localparam int unsigned SEQ_W      = 12;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned SET_ADDR_W = 8;
   localparam int unsigned SET_DATA_W = 32;

   // Context-packet header identity
   localparam logic [3:0]  CTX_TYPE = 4'h4;
   localparam logic [15:0] CTX_LEN  = 16'd6;

   // Settings register offsets relative to BASE
   localparam int unsigned REG_FILTER_SID = 0;
   localparam int unsigned REG_FILTER_EN  = 1;

   // Upper half of beat0
   typedef struct packed {
      logic [3:0]       pkt_type;
      logic [SEQ_W-1:0] seqnum;
      logic [15:0]      len;
   } hdr_t;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_TIME,
      ST_BODY,
      ST_EMIT,
      ST_DRAIN
   } state_t;

   // Increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/tx_resp_hdr_check.sv
// Beat0 validation: type/length match plus optional SID filter held in settings registers.
module tx_resp_hdr_check
   import tx_resp_pkg::*;
#(
   parameter int unsigned BASE = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  set_stb,
   input  logic [SET_ADDR_W-1:0] set_addr,
   input  logic [SET_DATA_W-1:0] set_data,
   input  logic [3:0]            pkt_type,
   input  logic [15:0]           pkt_len,
   input  logic [SID_W-1:0]      sid,
   output logic                  hdr_ok_c
);

   logic [SID_W-1:0] filter_sid;
   logic             filter_en;

   // Settings bus writes; not affected by the parser's synchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filter_sid <= '0;
         filter_en  <= 1'b0;
      end else if (set_stb) begin
         if (set_addr == SET_ADDR_W'(BASE + REG_FILTER_SID)) filter_sid <= set_data;
         if (set_addr == SET_ADDR_W'(BASE + REG_FILTER_EN))  filter_en  <= set_data[0];
      end
   end

   // Header acceptance
   always_comb begin
      hdr_ok_c = (pkt_type == CTX_TYPE) && (pkt_len == CTX_LEN) &&
                 (!filter_en || (sid == filter_sid));
   end

endmodule

// File: rtl/tx_response_parser.sv
// Parses 3-beat context reply packets into ack/error events with diagnostics.
// Optional: define TX_RESP_PARSER_SEQ_CHECK_EN to build reply-seqnum continuity checking.
module tx_response_parser
   import tx_resp_pkg::*;
#(
   parameter int unsigned BASE = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  set_stb,
   input  logic [SET_ADDR_W-1:0] set_addr,
   input  logic [SET_DATA_W-1:0] set_data,
   input  logic [DATA_W-1:0]     i_tdata,
   input  logic                  i_tlast,
   input  logic                  i_tvalid,
   output logic                  i_tready,
   output logic [SID_W-1:0]      evt_sid,
   output logic [SEQ_W-1:0]      evt_seqnum,
   output logic [63:0]           evt_time,
   output logic [63:0]           evt_code,
   output logic                  evt_is_error,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [CNT_W-1:0]      bad_pkt_cnt,
   output logic [CNT_W-1:0]      seq_gap_cnt
);

   state_t state;
   hdr_t   beat_hdr;
   logic   xfer;
   logic   hdr_ok_c;

   assign beat_hdr = hdr_t'(i_tdata[63:32]);
   assign xfer     = i_tvalid & i_tready;

   tx_resp_hdr_check #(.BASE(BASE)) u_hdr_check (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .pkt_type (beat_hdr.pkt_type),
      .pkt_len  (beat_hdr.len),
      .sid      (i_tdata[SID_W-1:0]),
      .hdr_ok_c (hdr_ok_c)
   );

   // Packet FSM with registered stream-ready, event fields and bad-packet counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_HDR;
         i_tready     <= 1'b0;
         evt_valid    <= 1'b0;
         evt_sid      <= '0;
         evt_seqnum   <= '0;
         evt_time     <= '0;
         evt_code     <= '0;
         evt_is_error <= 1'b0;
         bad_pkt_cnt  <= '0;
      end else if (clear) begin
         state        <= ST_HDR;
         i_tready     <= 1'b1;
         evt_valid    <= 1'b0;
         evt_sid      <= '0;
         evt_seqnum   <= '0;
         evt_time     <= '0;
         evt_code     <= '0;
         evt_is_error <= 1'b0;
         bad_pkt_cnt  <= '0;
      end else begin
         i_tready <= 1'b1;
         case (state)
            ST_HDR: begin
               if (xfer) begin
                  evt_sid    <= i_tdata[SID_W-1:0];
                  evt_seqnum <= beat_hdr.seqnum;
                  if (!hdr_ok_c || i_tlast) begin
                     bad_pkt_cnt <= sat_inc(bad_pkt_cnt);
                     state       <= i_tlast ? ST_HDR : ST_DRAIN;
                  end else begin
                     state <= ST_TIME;
                  end
               end
            end
            ST_TIME: begin
               if (xfer) begin
                  evt_time <= i_tdata;
                  if (i_tlast) begin
                     bad_pkt_cnt <= sat_inc(bad_pkt_cnt);
                     state       <= ST_HDR;
                  end else begin
                     state <= ST_BODY;
                  end
               end
            end
            ST_BODY: begin
               if (xfer) begin
                  if (i_tlast) begin
                     evt_code     <= i_tdata;
                     evt_is_error <= |i_tdata[63:12];
                     evt_valid    <= 1'b1;
                     i_tready     <= 1'b0;
                     state        <= ST_EMIT;
                  end else begin
                     bad_pkt_cnt <= sat_inc(bad_pkt_cnt);
                     state       <= ST_DRAIN;
                  end
               end
            end
            ST_EMIT: begin
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  state     <= ST_HDR;
               end else begin
                  i_tready <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (xfer && i_tlast) state <= ST_HDR;
            end
            default: state <= ST_HDR;
         endcase
      end
   end

`ifdef TX_RESP_PARSER_SEQ_CHECK_EN
   logic [SEQ_W-1:0] exp_seq;
   logic             exp_vld;
   logic [CNT_W-1:0] gap_cnt;

   // Seqnum continuity: compare each emitted reply against the previous one plus one
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_seq <= '0;
         exp_vld <= 1'b0;
         gap_cnt <= '0;
      end else if (clear) begin
         exp_seq <= '0;
         exp_vld <= 1'b0;
         gap_cnt <= '0;
      end else if ((state == ST_BODY) && xfer && i_tlast) begin
         if (exp_vld && (evt_seqnum != exp_seq)) gap_cnt <= sat_inc(gap_cnt);
         exp_seq <= evt_seqnum + SEQ_W'(1);
         exp_vld <= 1'b1;
      end
   end

   assign seq_gap_cnt = gap_cnt;
`else
   assign seq_gap_cnt = '0;
`endif

endmodule
